// File: rtl/vsm_out_register.sv
// Output buffer between the internal data bus and an external ready/valid consumer.
// Words captured from B on LoadOut are queued in a small FIFO and presented at DataOut.
// A capture into a full buffer with no same-cycle pop is dropped and flagged on Overflow.
module vsm_out_register #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic [WIDTH-1:0] B,
   input  logic             LoadOut,
   output logic             Full,
   output logic [WIDTH-1:0] DataOut,
   output logic             OutValid,
   input  logic             OutReady,
   output logic             Overflow,
   input  logic             ClrErr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             r_overflow;

   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [AW:0]      w_count_d;

   // Handshake decode; a full buffer still accepts a capture when the head leaves this cycle.
   always_comb begin
      w_pop  = OutValid & OutReady;
      w_push = LoadOut & ((r_count < CntFull) | w_pop);
      w_drop = LoadOut & ~w_push;
   end

   // Occupancy next-state: simultaneous push and pop leave the count unchanged.
   always_comb begin
      w_count_d = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_d = r_count + 1'b1;
         2'b01:   w_count_d = r_count - 1'b1;
         default: w_count_d = r_count;
      endcase
   end

   // Pointer, count and sticky overflow state; reset discards everything buffered.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= w_count_d;
         // A drop in the same cycle as a clear wins.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (ClrErr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Entry storage; contents are don't-care after reset since the count gates visibility.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= B;
      end
   end

   // Status and head word, all derived from registered state.
   always_comb begin
      OutValid = (r_count != '0);
      Full     = (r_count == CntFull);
      Overflow = r_overflow;
      DataOut  = OutValid ? r_mem[r_rptr] : '0;
   end

endmodule

// File: tb/tb_vsm_out_register.sv
// Directed bench for vsm_out_register with a queue scoreboard of expected output words.
module tb_vsm_out_register;

   logic       Clk;
   logic       ResetN;
   logic [3:0] B;
   logic       LoadOut;
   logic       Full;
   logic [3:0] DataOut;
   logic       OutValid;
   logic       OutReady;
   logic       Overflow;
   logic       ClrErr;

   int         n_tests;
   int         n_fail;
   int         m_count;
   logic       m_ovf;
   logic [3:0] q[$];

   vsm_out_register #(
      .WIDTH(4),
      .DEPTH(4)
   ) dut (
      .Clk      (Clk),
      .ResetN   (ResetN),
      .B        (B),
      .LoadOut  (LoadOut),
      .Full     (Full),
      .DataOut  (DataOut),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Overflow (Overflow),
      .ClrErr   (ClrErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered at posedge+1; drives one cycle of inputs, checks at the falling edge, returns at
   // the next posedge+1 after checking the sticky flag.
   task automatic step(input string tag, input logic ld, input logic [3:0] b, input logic rdy,
                       input logic clr);
      logic pop;
      logic push;
      LoadOut  = ld;
      B        = b;
      OutReady = rdy;
      ClrErr   = clr;
      #4;
      chk({tag, "_valid"}, OutValid, m_count != 0);
      chk({tag, "_full"}, Full, m_count == 4);
      pop = (m_count != 0) && rdy;
      if (m_count != 0) begin
         chk({tag, "_data"}, DataOut, q[0]);
         if (pop) void'(q.pop_front());
      end else begin
         chk({tag, "_data_zero"}, DataOut, 0);
      end
      push = ld && ((m_count < 4) || pop);
      if (push) q.push_back(b);
      if (push && !pop) m_count++;
      else if (pop && !push) m_count--;
      if (ld && !push) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(posedge Clk);
      #1;
      chk({tag, "_ovf"}, Overflow, m_ovf);
   endtask

   initial begin
      int pushed;
      int budget;
      n_tests  = 0;
      n_fail   = 0;
      m_count  = 0;
      m_ovf    = 1'b0;
      ResetN   = 1'b0;
      B        = '0;
      LoadOut  = 1'b0;
      OutReady = 1'b0;
      ClrErr   = 1'b0;

      // Reset state, with strobes ignored while reset is held
      #2;
      chk("rst_valid", OutValid, 0);
      chk("rst_full", Full, 0);
      chk("rst_ovf", Overflow, 0);
      chk("rst_data", DataOut, 0);
      LoadOut  = 1'b1;
      OutReady = 1'b1;
      @(posedge Clk);
      #1;
      chk("rst_hold_valid", OutValid, 0);
      LoadOut  = 1'b0;
      OutReady = 1'b0;
      ResetN   = 1'b1;
      @(posedge Clk);
      #1;

      // Single word: capture, hold under stall, then consume
      step("single_load", 1, 4'hA, 0, 0);
      step("single_hold0", 0, 0, 0, 0);
      step("single_hold1", 0, 0, 0, 0);
      step("single_pop", 0, 0, 1, 0);
      step("single_empty", 0, 0, 0, 0);

      // Fill and ordered drain
      for (int i = 1; i <= 4; i++) step("fill", 1, 4'(i), 0, 0);
      step("fill_full", 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("drain", 0, 0, 1, 0);
      step("drain_empty", 0, 0, 0, 0);

      // Overflow drop, drain unaffected, then clear
      for (int i = 1; i <= 4; i++) step("ovf_fill", 1, 4'(i), 0, 0);
      step("ovf_drop", 1, 4'h5, 0, 0);
      step("ovf_hold", 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("ovf_drain", 0, 0, 1, 0);
      step("ovf_clr", 0, 0, 0, 1);
      step("ovf_after_clr", 0, 0, 0, 0);

      // Full with simultaneous push and pop
      for (int i = 1; i <= 4; i++) step("pp_fill", 1, 4'(i), 0, 0);
      step("pp_both", 1, 4'h9, 1, 0);
      step("pp_full", 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("pp_drain", 0, 0, 1, 0);
      step("pp_empty", 0, 0, 0, 0);

      // Wrap-around with random consumer stalls; never offer a word that would be dropped
      pushed = 0;
      budget = 0;
      while ((pushed < 10 || m_count != 0) && budget < 200) begin
         if (pushed < 10 && m_count < 4) begin
            step("wrap", 1, 4'(pushed), 1'($urandom_range(0, 1)), 0);
            pushed++;
         end else begin
            step("wrap", 0, 0, 1'($urandom_range(0, 1)), 0);
         end
         budget++;
      end
      chk("wrap_done_in_budget", (budget < 200), 1);
      chk("wrap_sb_empty", q.size(), 0);
      step("wrap_empty", 0, 0, 0, 0);

      // Async reset mid-operation with 3 words buffered and Overflow set (drop beats clear)
      for (int i = 1; i <= 4; i++) step("ar_fill", 1, 4'(i), 0, 0);
      step("ar_drop_clr", 1, 4'h7, 0, 1);
      step("ar_pop", 0, 0, 1, 0);
      LoadOut  = 1'b1;
      B        = 4'hF;
      OutReady = 1'b1;
      ClrErr   = 1'b0;
      #3;
      ResetN = 1'b0;
      #1;
      chk("ar_valid", OutValid, 0);
      chk("ar_full", Full, 0);
      chk("ar_ovf", Overflow, 0);
      chk("ar_data", DataOut, 0);
      q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      @(posedge Clk);
      #1;
      chk("ar_hold_valid", OutValid, 0);
      LoadOut  = 1'b0;
      OutReady = 1'b0;
      ResetN   = 1'b1;
      @(posedge Clk);
      #1;
      step("ar_push6", 1, 4'h6, 0, 0);
      step("ar_see6", 0, 0, 0, 0);
      step("ar_pop6", 0, 0, 1, 0);
      step("ar_empty", 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
